// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM state type and address-split helpers for dcache_wt.
// Revision 1.0
`default_nettype none

package dcache_pkg;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int WOFF  = $clog2(WORDS);
  localparam int IDXW  = $clog2(LINES);
  localparam int TAGW  = 30 - WOFF - IDXW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } dcache_state_t;

  function automatic logic [WOFF-1:0] addr_word(input logic [31:0] addr);
    return addr[WOFF+1:2];
  endfunction

  function automatic logic [IDXW-1:0] addr_idx(input logic [31:0] addr);
    return addr[WOFF+IDXW+1:WOFF+2];
  endfunction

  function automatic logic [TAGW-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:WOFF+IDXW+2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/data storage with async read, sync write and async valid clear.
// Revision 1.0
`default_nettype none

module dcache_array
  import dcache_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [IDXW-1:0] rd_idx,
  input  logic [WOFF-1:0] rd_word,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  output logic [31:0]     rd_data,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [WOFF-1:0] wr_word,
  input  logic [31:0]     wr_data,
  input  logic            fill_en,
  input  logic [IDXW-1:0] fill_idx,
  input  logic [TAGW-1:0] fill_tag,
  input  logic            inval_en,
  input  logic [IDXW-1:0] inval_idx
);

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx][rd_word];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (inval_en) valid_q[inval_idx] <= 1'b0;
      if (fill_en)  valid_q[fill_idx]  <= 1'b1;
    end
  end

  // Payload RAMs are intentionally unreset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (wr_en)   data_mem[wr_idx][wr_word] <= wr_data;
    if (fill_en) tag_mem[fill_idx]         <= fill_tag;
  end

endmodule

`default_nettype wire

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through, no-write-allocate data cache with req/ack memory port.
// Revision 1.0
`default_nettype none

module dcache_wt
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  dcache_state_t state_q, state_d;

  logic [WOFF-1:0] cnt_q;
  logic [TAGW-1:0] ltag_q;
  logic [IDXW-1:0] lidx_q;

  logic [WOFF-1:0] word;
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;

  logic            line_valid;
  logic [TAGW-1:0] line_tag;
  logic [31:0]     line_data;
  logic            hit;

  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [WOFF-1:0] wr_word;
  logic [31:0]     wr_data;
  logic            fill_en;
  logic            start_refill;
  logic            stall_int;
  logic            req_int;

  assign word = addr_word(a);
  assign idx  = addr_idx(a);
  assign tag  = addr_tag(a);
  assign hit  = line_valid && (line_tag == tag);

  dcache_array u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (idx),
    .rd_word   (word),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .fill_en   (fill_en),
    .fill_idx  (lidx_q),
    .fill_tag  (ltag_q),
    .inval_en  (start_refill),
    .inval_idx (idx)
  );

  always_comb begin
    state_d      = state_q;
    stall_int    = 1'b0;
    req_int      = 1'b0;
    mem_we       = 1'b0;
    mem_a        = '0;
    mem_wd       = '0;
    wr_en        = 1'b0;
    wr_idx       = idx;
    wr_word      = word;
    wr_data      = wd;
    fill_en      = 1'b0;
    start_refill = 1'b0;
    rd           = (re && hit) ? line_data : '0;

    case (state_q)
      IDLE: begin
        if (we) begin
          stall_int = 1'b1;
          state_d   = WRITE;
        end else if (re && !hit) begin
          stall_int    = 1'b1;
          start_refill = 1'b1;
          state_d      = REFILL;
        end
      end

      REFILL: begin
        stall_int = 1'b1;
        req_int   = 1'b1;
        mem_a     = {ltag_q, lidx_q, cnt_q, 2'b00};
        wr_idx    = lidx_q;
        wr_word   = cnt_q;
        wr_data   = mem_rdata;
        if (mem_ack) begin
          wr_en = 1'b1;
          if (cnt_q == WOFF'(WORDS - 1)) begin
            fill_en = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WRITE: begin
        req_int   = 1'b1;
        mem_we    = 1'b1;
        mem_a     = {a[31:2], 2'b00};
        mem_wd    = wd;
        // Releasing stall on the ack cycle lets the store retire on the same edge.
        stall_int = !mem_ack;
        if (mem_ack) begin
          wr_en   = hit;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign stall   = stall_int & ~reset;
  assign mem_req = req_int & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ltag_q  <= '0;
      lidx_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_refill) begin
        cnt_q  <= '0;
        ltag_q <= tag;
        lidx_q <= idx;
      end else if (state_q == REFILL && mem_ack) begin
        cnt_q <= cnt_q + WOFF'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed plus randomized checks of dcache_wt against a set-residency and memory model.
// Revision 1.0
`default_nettype none

module tb_dcache_wt;

  logic        clk;
  logic        reset;
  logic        re;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  dcache_wt dut (
    .clk       (clk),
    .reset     (reset),
    .re        (re),
    .we        (we),
    .a         (a),
    .wd        (wd),
    .rd        (rd),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing memory: 8 KB, hashed initial contents, written words kept separately.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic [31:0] seed;
  logic [31:0] bmem  [2048];
  bit          wflag [2048];
  logic [10:0] mi;
  int          ack_delay;
  int          wait_cnt;
  txn_t        txq[$];

  assign mi        = mem_a[12:2];
  assign mem_rdata = wflag[mi] ? bmem[mi] : (({21'b0, mi} * 32'h9E37_79B1) ^ seed);
  assign mem_ack   = mem_req && (wait_cnt == ack_delay);

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      txq.push_back('{wr: mem_we, addr: mem_a, data: mem_wd});
      if (mem_we) begin
        bmem[mi]  <= mem_wd;
        wflag[mi] <= 1'b1;
      end
      wait_cnt <= 0;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // Reference: architectural memory plus which line (addr/16) each of 16 sets holds.
  logic [31:0] ref_mem [2048];
  bit          mvalid  [16];
  logic [27:0] mline   [16];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr);
    int          set;
    int          cyc;
    logic [31:0] base;
    logic [10:0] w;
    bit          exp_hit;
    set     = int'(addr[7:4]);
    base    = {addr[31:4], 4'b0000};
    w       = addr[12:2];
    exp_hit = mvalid[set] && (mline[set] == addr[31:4]);
    @(negedge clk);
    re = 1'b1; we = 1'b0; a = addr; wd = $urandom;
    #1;
    if (exp_hit) begin
      check("hit_stall", 32'(stall), 32'd0);
      check("hit_rd", rd, ref_mem[w]);
      check("hit_noreq", 32'(mem_req), 32'd0);
    end else begin
      txq.delete();
      check("miss_stall", 32'(stall), 32'd1);
      cyc = 1;
      while (stall && cyc < 200) begin
        @(negedge clk);
        #1;
        if (stall) cyc++;
      end
      check("miss_stall_cycles", 32'(cyc), 32'(1 + 4 * (ack_delay + 1)));
      check("miss_rd", rd, ref_mem[w]);
      check("miss_ntxn", 32'(txq.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
        if (k < txq.size()) begin
          check("miss_txn_addr", txq[k].addr, base + 32'(4 * k));
          check("miss_txn_rd", 32'(txq[k].wr), 32'd0);
        end
      end
      mvalid[set] = 1'b1;
      mline[set]  = addr[31:4];
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic also_re);
    int cyc;
    @(negedge clk);
    we = 1'b1; re = also_re; a = addr; wd = data;
    #1;
    txq.delete();
    check("wr_first_stall", 32'(stall), 32'd1);
    check("wr_first_noreq", 32'(mem_req), 32'd0);
    cyc = 1;
    while (stall && cyc < 200) begin
      @(negedge clk);
      #1;
      if (stall) cyc++;
    end
    check("wr_stall_cycles", 32'(cyc), 32'(1 + ack_delay));
    check("wr_req", 32'(mem_req), 32'd1);
    check("wr_we", 32'(mem_we), 32'd1);
    check("wr_addr", mem_a, {addr[31:2], 2'b00});
    check("wr_data", mem_wd, data);
    @(posedge clk);
    #1;
    check("wr_ntxn", 32'(txq.size()), 32'd1);
    ref_mem[addr[12:2]] = data;
  endtask

  task automatic do_idle();
    @(negedge clk);
    re = 1'b0; we = 1'b0; a = 32'h8000_0000 | $urandom; wd = $urandom;
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_noreq", 32'(mem_req), 32'd0);
    check("idle_rd", rd, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int          cyc;
    int          op;

    seed      = $urandom;
    reset     = 1'b1;
    re        = 1'b1;
    we        = 1'b0;
    a         = 32'h100;
    wd        = 32'h0;
    ack_delay = 2;
    for (int i = 0; i < 2048; i++) ref_mem[i] = (32'(i) * 32'h9E37_79B1) ^ seed;
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mline[i]  = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_req", 32'(mem_req), 32'd0);
    check("reset_rd", rd, 32'd0);
    @(negedge clk);
    reset = 1'b0; re = 1'b0;

    // Cold miss, hit, write hit, write miss without allocation.
    do_read(32'h100);
    do_read(32'h108);
    do_write(32'h104, 32'd7, 1'b0);
    do_read(32'h104);
    check("wr_hit_value", ref_mem[32'h104 >> 2], 32'd7);
    do_write(32'h200, 32'd5, 1'b0);
    do_read(32'h200);
    do_idle();

    // Zero-wait memory with conflict eviction in set 0.
    ack_delay = 0;
    do_read(32'h100);
    do_read(32'h1100);
    do_read(32'h100);
    do_idle();

    // Reset in the middle of a refill.
    ack_delay = 1;
    do_read(32'h1100);
    @(negedge clk);
    re = 1'b1; we = 1'b0; a = 32'h100;
    txq.delete();
    cyc = 0;
    while (txq.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmid_acks", 32'(txq.size()), 32'd2);
    reset = 1'b1;
    #1;
    check("rstmid_req", 32'(mem_req), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    repeat (3) @(negedge clk);
    check("rstmid_quiet", 32'(txq.size()), 32'd2);
    reset = 1'b0; re = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    do_read(32'h100);
    do_read(32'h1100);

    // Randomized traffic concentrated on four sets and four tags.
    for (int n = 0; n < 80; n++) begin
      ack_delay = $urandom_range(0, 3);
      ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (op < 5)      do_read(ra);
      else if (op < 8) do_write(ra, $urandom, 1'($urandom_range(0, 1)));
      else             do_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
Direct-mapped, write-through, no-write-allocate data cache between the pipeline's Memory stage and a slow word-wide backing memory. It serves read hits combinationally in the same cycle. On a read miss, a write, or an outstanding refill it asserts stall, which freezes the pipeline. It runs a req/ack handshake to memory for line refills and write-throughs.

Parameters:
LINES, 16, number of cache lines (power of 2)
WORDS, 4, 32-bit words per line (power of 2)
Derived: WOFF = log2(WORDS); IDXW = log2(LINES); TAGW = 30 - WOFF - IDXW

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
re  in  1  CPU read request (load in M stage)
we  in  1  CPU write request (store in M stage)
a  in  32  CPU byte address; a[1:0] ignored
wd  in  32  CPU write data
rd  out  32  CPU read data
stall  out  1  hold the pipeline this cycle
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write, 0 = read
mem_a  out  32  memory word address, bits [1:0] = 0
mem_wd  out  32  memory write data
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  transaction completes at this posedge

Behaviour:
- Address split: word = a[WOFF+1:2]; idx = a[WOFF+IDXW+1:WOFF+2]; tag = a[31:WOFF+IDXW+2].
- hit = valid[idx] & (tagram[idx] == tag).
- States: IDLE, REFILL, WRITE.
- Reset (async):
  - state = IDLE; all valid bits = 0; refill counter = 0.
  - While reset is high: mem_req = 0, stall = 0.
  - Data and tag RAM contents are not reset.
- Upstream rule: re, we, a and wd are held stable while stall = 1. If re and we are both high, we takes precedence.
- IDLE:
  - re & hit: rd = data[idx][word]; stall = 0; no mem_req.
  - re & ~hit: stall = 1; latch the line address {tag, idx}; counter = 0; go to REFILL next cycle.
  - we: stall = 1; go to WRITE next cycle.
  - Otherwise: stall = 0. rd = 0 whenever there is no hit.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_a = {latched tag, idx, counter, 2'b00}; stall = 1.
  - Each posedge with mem_ack: write mem_rdata into data[idx][counter]; counter += 1.
  - Counter wraps at WORDS-1.
  - On the ack of word WORDS-1: set valid[idx] = 1 and tagram[idx] = tag; go to IDLE.
  - The held request then hits next cycle with stall = 0.
  - Read-miss latency = sum of WORDS memory transactions + 1 cycle.
  - valid[idx] is cleared at REFILL entry, so a partial line is never reported as a hit.
- WRITE:
  - mem_req = 1, mem_we = 1, mem_a = {a[31:2], 2'b00}, mem_wd = wd.
  - stall = ~mem_ack (combinational), so the pipeline advances on the ack edge.
  - On the ack edge: if hit, data[idx][word] = wd (no allocation on miss); go to IDLE.
- Memory handshake:
  - mem_req, mem_a, mem_we and mem_wd are stable from assertion until the ack edge.
  - mem_ack is ignored when mem_req = 0.
  - A zero-wait ack (same cycle as req) is legal; the refill then takes WORDS cycles.
- Back-to-back: a new request in the IDLE cycle following a completion is accepted normally.
- Conflict miss: refilling an index with a different tag overwrites the line; there is no writeback because the cache is write-through.
- Reset mid-transaction: the transaction is abandoned immediately, with no further writes to the arrays. Memory must tolerate a dropped mem_req.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum dcache_state_t {IDLE, REFILL, WRITE}
  - field-width localparams (WOFF, IDXW, TAGW)
  - address-split helper functions
- One sub-module, dcache_array: tag/valid/data storage.
  - Async read by idx/word.
  - Synchronous word write and tag/valid write on posedge clk.
  - Async valid clear on reset.
- dcache_wt holds the FSM, refill counter, latched line address and the stall/handshake logic.

Test Plan:
1. Cold read miss: after reset, re at a=0x100, memory acks 2 cycles after each req → reads issued at 0x100, 0x104, 0x108, 0x10C; stall high throughout; the cycle after the last ack, stall=0 and rd=mem[0x100].
2. Read hit: then re at 0x108 → stall=0 in the same cycle, rd=mem[0x108], mem_req stays 0.
3. Write hit: we a=0x104 wd=7 → mem_req=1, mem_we=1, mem_a=0x104, mem_wd=7; stall drops in the ack cycle; a following re at 0x104 hits with rd=7 and no mem_req.
4. Write miss, no allocate: we a=0x200 wd=5 → one memory write; a following re at 0x200 misses and refills 0x200–0x20C.
5. Conflict eviction plus zero-wait memory: mem_ack tied to 1; re 0x100, then re 0x1100 (same idx 0) → 4-cycle refill evicts the line; re 0x100 misses again.
6. Reset mid-refill: assert reset after 2 refill acks → mem_req and stall drop immediately; after release, re at 0x100 misses and the refill restarts at word 0 (0x100).
